// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Command interpreter and small control-register bank placed right after an
// SPI slave. Each cmd_valid strobe delivers one command byte that is decoded
// as SET_ADDR / LOAD_LO / COMMIT / MISC. 'response' is re-registered every
// clock so that the SPI slave always has the byte for its next transaction.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   cmd        in   [7:0] command byte, qualified by cmd_valid
//   cmd_valid  in   one-cycle strobe per command byte
//   response   out  [7:0] registered read-back / status byte
//   ext_in     in   [7:0] live value seen through register NREGS-1
//   regs_flat  out  [8*(NREGS-1)-1:0] R/W registers, reg i at [8*i+7:8*i]
//   wr_strobe  out  one-cycle pulse on every successful commit
//   wr_addr    out  [2:0] address of the last successful commit
// -----------------------------------------------------------------------------
module spi_reg_bank #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               cmd,
  input  logic                     cmd_valid,
  output logic [7:0]               response,
  input  logic [7:0]               ext_in,
  output logic [8*(NREGS-1)-1:0]   regs_flat,
  output logic                     wr_strobe,
  output logic [2:0]               wr_addr
);

  localparam int         NRW       = NREGS - 1;
  localparam logic [2:0] LAST_ADDR = 3'(NREGS - 1);

  localparam logic [1:0] OP_SET_ADDR = 2'b00;
  localparam logic [1:0] OP_LOAD_LO  = 2'b01;
  localparam logic [1:0] OP_COMMIT   = 2'b10;
  localparam logic [1:0] OP_MISC     = 2'b11;

  localparam logic [5:0] MISC_NOP      = 6'h00;
  localparam logic [5:0] MISC_STATUS   = 6'h01;
  localparam logic [5:0] MISC_SOFT_RST = 6'h3F;

  logic [8*NRW-1:0] regs_r;
  logic [2:0]       addr_r;
  logic [3:0]       stage_r;
  logic             err_r;
  logic [6:0]       cmd_count_r;
  logic             status_mode_r;
  logic [7:0]       status_snap_r;

  logic [7:0]       rd_data_s;
  logic [7:0]       commit_val_s;
  logic [2:0]       addr_inc_s;

  // Select one R/W register by address; compares against constant indices so
  // no out-of-range part-select is ever formed.
  function automatic logic [7:0] reg_at(input logic [8*NRW-1:0] bank,
                                        input logic [2:0]       a);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NRW; i++) begin
      if (a == 3'(i)) begin
        v = bank[8*i +: 8];
      end
    end
    return v;
  endfunction

  assign regs_flat = regs_r;

  // Read mux, commit value and wrapping address increment.
  always_comb begin
    rd_data_s    = reg_at(regs_r, addr_r);
    commit_val_s = {cmd[3:0], stage_r};
    if (addr_r == LAST_ADDR) begin
      addr_inc_s = 3'd0;
    end else begin
      addr_inc_s = addr_r + 3'd1;
    end
  end

  // Command decode and all architectural state updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r        <= {NRW{RESET_VAL}};
      addr_r        <= 3'd0;
      stage_r       <= 4'd0;
      err_r         <= 1'b0;
      cmd_count_r   <= 7'd0;
      status_mode_r <= 1'b0;
      status_snap_r <= 8'h00;
      wr_strobe     <= 1'b0;
      wr_addr       <= 3'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (cmd_valid) begin
        cmd_count_r   <= cmd_count_r + 7'd1;
        status_mode_r <= 1'b0;
        case (cmd[7:6])
          OP_SET_ADDR: begin
            if ({1'b0, cmd[2:0]} < 4'(NREGS)) begin
              addr_r <= cmd[2:0];
            end else begin
              err_r <= 1'b1;
            end
          end
          OP_LOAD_LO: begin
            stage_r <= cmd[3:0];
          end
          OP_COMMIT: begin
            if (addr_r == LAST_ADDR) begin
              err_r <= 1'b1;
            end else begin
              for (int i = 0; i < NRW; i++) begin
                if (addr_r == 3'(i)) begin
                  regs_r[8*i +: 8] <= commit_val_s;
                end
              end
              wr_strobe <= 1'b1;
              wr_addr   <= addr_r;
            end
            // Increment is independent of the write outcome.
            if (cmd[4]) begin
              addr_r <= addr_inc_s;
            end
          end
          OP_MISC: begin
            case (cmd[5:0])
              MISC_NOP: begin
              end
              MISC_STATUS: begin
                // Snapshot uses the values before this command's updates.
                status_snap_r <= {err_r, cmd_count_r};
                err_r         <= 1'b0;
                status_mode_r <= 1'b1;
              end
              MISC_SOFT_RST: begin
                regs_r  <= {NRW{RESET_VAL}};
                addr_r  <= 3'd0;
                stage_r <= 4'd0;
              end
              default: begin
                err_r <= 1'b1;
              end
            endcase
          end
          default: begin
            err_r <= 1'b1;
          end
        endcase
      end
    end
  end

  // Response byte for the next SPI transaction, refreshed every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      response <= 8'h00;
    end else if (status_mode_r) begin
      response <= status_snap_r;
    end else if (addr_r == LAST_ADDR) begin
      response <= ext_in;
    end else begin
      response <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  cmd;
  logic        cmd_valid8;
  logic        cmd_valid4;
  logic [7:0]  ext_in8;
  logic [7:0]  ext_in4;
  logic [7:0]  response8;
  logic [7:0]  response4;
  logic [55:0] regs_flat8;
  logic [23:0] regs_flat4;
  logic        wr_strobe8;
  logic        wr_strobe4;
  logic [2:0]  wr_addr8;
  logic [2:0]  wr_addr4;

  int n_checks = 0;
  int n_errors = 0;

  spi_reg_bank #(.NREGS(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid8),
    .response(response8), .ext_in(ext_in8), .regs_flat(regs_flat8),
    .wr_strobe(wr_strobe8), .wr_addr(wr_addr8)
  );

  spi_reg_bank #(.NREGS(4), .RESET_VAL(8'h00)) u_dut4 (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid4),
    .response(response4), .ext_in(ext_in4), .regs_flat(regs_flat4),
    .wr_strobe(wr_strobe4), .wr_addr(wr_addr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One command to the selected DUT; returns at the negedge after the sampling edge.
  task automatic send(input logic [7:0] c, input bit to4);
    @(negedge clk);
    cmd = c;
    if (to4) cmd_valid4 = 1'b1;
    else     cmd_valid8 = 1'b1;
    @(negedge clk);
    cmd_valid4 = 1'b0;
    cmd_valid8 = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cmd = 8'h00; cmd_valid8 = 1'b0; cmd_valid4 = 1'b0;
    ext_in8 = 8'h5C; ext_in4 = 8'h9D;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    // reset state
    chk("rst_resp", response8, 8'h00);
    chk("rst_strobe", wr_strobe8, 1'b0);
    chk("rst_waddr", wr_addr8, 3'd0);
    chk("rst_regs", regs_flat8, 56'h0);

    // T2 write / read-after-write to reg2
    send(8'h02, 0); send(8'h45, 0); send(8'h8A, 0);
    chk("t2_strobe", wr_strobe8, 1'b1);
    chk("t2_waddr", wr_addr8, 3'd2);
    chk("t2_reg2", regs_flat8[23:16], 8'hA5);
    step();
    chk("t2_strobe_one", wr_strobe8, 1'b0);
    chk("t2_resp", response8, 8'hA5);
    // reg0 = 0x73
    send(8'h00, 0); send(8'h43, 0); send(8'h87, 0);
    chk("t2_waddr0", wr_addr8, 3'd0);
    chk("t2_reg0", regs_flat8[7:0], 8'h73);

    // T3 commit with auto-inc to the read-only slot, then wrap
    send(8'h06, 0); send(8'h41, 0); send(8'h92, 0);
    chk("t3_strobe", wr_strobe8, 1'b1);
    chk("t3_waddr", wr_addr8, 3'd6);
    chk("t3_reg6", regs_flat8[55:48], 8'h21);
    step();
    chk("t3_resp_ext", response8, 8'h5C);
    ext_in8 = 8'hC3;
    step();
    chk("t3_resp_ext_live", response8, 8'hC3);
    send(8'h93, 0);
    chk("t3_err_nostrobe", wr_strobe8, 1'b0);
    step();
    chk("t3_wrap_resp", response8, 8'h73);
    chk("t3_regs", regs_flat8, 56'h21_00_00_00_A5_00_73);

    // T4 status: 10 commands so far, err set
    send(8'hC1, 0);
    step();
    chk("t4_status1", response8, 8'h8A);
    send(8'hC1, 0);
    step();
    chk("t4_status2", response8, 8'h0B);
    send(8'hC0, 0);
    step();
    chk("t4_nop_resp", response8, 8'h73);

    // T6 soft reset followed back-to-back by SET_ADDR 3
    @(negedge clk);
    cmd = 8'hFF; cmd_valid8 = 1'b1;
    @(negedge clk);
    cmd = 8'h03;
    @(negedge clk);
    cmd_valid8 = 1'b0;
    chk("t6_regs_clr", regs_flat8, 56'h0);
    send(8'h8E, 0);
    chk("t6_waddr3", wr_addr8, 3'd3);
    chk("t6_stage_clr", regs_flat8[31:24], 8'hE0);
    // 16 commands issued; bring count to 127
    for (int i = 0; i < 111; i++) send(8'hC0, 0);
    send(8'hC1, 0);
    step();
    chk("t6_count127", response8, 8'h7F);
    send(8'hC1, 0);
    step();
    chk("t6_count_wrap0", response8, 8'h00);
    send(8'hC1, 0);
    step();
    chk("t6_count_wrap1", response8, 8'h01);

    // T1 reset pulse in the middle of a command
    send(8'h00, 0);
    @(negedge clk);
    cmd = 8'h8F; cmd_valid8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    cmd_valid8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_resp", response8, 8'h00);
    chk("t1_strobe", wr_strobe8, 1'b0);
    chk("t1_waddr", wr_addr8, 3'd0);
    chk("t1_regs", regs_flat8, 56'h0);
    step();
    chk("t1_resp_after", response8, 8'h00);

    // T5 error cases on the 4-register bank
    send(8'h39, 1); send(8'h76, 1); send(8'h8B, 1);
    chk("t5_waddr", wr_addr4, 3'd1);
    chk("t5_reg1", regs_flat4[15:8], 8'hB6);
    send(8'h07, 1);
    step();
    chk("t5_addr_kept", response4, 8'hB6);
    send(8'hC1, 1);
    step();
    chk("t5_status_err", response4, 8'h84);
    send(8'hC5, 1);
    step();
    chk("t5_bad_misc_resp", response4, 8'hB6);
    chk("t5_bad_misc_regs", regs_flat4, 24'h00_B6_00);
    send(8'hC1, 1);
    step();
    chk("t5_status_err2", response4, 8'h86);
    send(8'h03, 1);
    step();
    chk("t5_ext_slot", response4, 8'h9D);
    chk("t5_dut8_idle", wr_strobe8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
